// File: rtl/led_pat_pkg.sv
// Shared types, button code constants and decode helpers for the LED pattern memory game.
package led_pat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECORD,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_CHECK,
    ST_PASS,
    ST_FAIL
  } state_t;

  localparam logic [1:0] CODE_IN1 = 2'b01;
  localparam logic [1:0] CODE_IN2 = 2'b10;
  localparam logic [1:0] CODE_IN3 = 2'b11;
  localparam logic [1:0] CODE_IN4 = 2'b00;

  // Map a button code onto the one-hot LED pattern for that button.
  function automatic logic [3:0] code_to_led(input logic [1:0] code);
    case (code)
      CODE_IN1: code_to_led = 4'b0001;
      CODE_IN2: code_to_led = 4'b0010;
      CODE_IN3: code_to_led = 4'b0100;
      default:  code_to_led = 4'b1000;  // CODE_IN4
    endcase
  endfunction

  // Status flags {busy, pass, fail} shown while sitting in a given state.
  function automatic logic [2:0] state_flags(input state_t st);
    case (st)
      ST_RECORD, ST_SHOW_ON, ST_SHOW_OFF, ST_CHECK: state_flags = 3'b100;
      ST_PASS:                                      state_flags = 3'b010;
      ST_FAIL:                                      state_flags = 3'b001;
      default:                                      state_flags = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/pattern_memory_step_timer.sv
// Loadable down-counter: o_done is high while the count reads 1, and the
// count parks at 0 afterwards instead of wrapping.
module step_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [TW-1:0] i_value,
  output logic          o_done
);

  logic [TW-1:0] r_count;

  // Load on request, otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign o_done = (r_count == TW'(1));

endmodule

// File: rtl/pattern_memory.sv
// Records a sequence of button codes, replays it on the LEDs with timed
// on/off steps, then checks the player's repeat and reports pass or fail.
// DEPTH must be at least 2.
import led_pat_pkg::*;

module pattern_memory #(
  parameter int DEPTH       = 8,
  parameter int SHOW_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 12500000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               code_in,
  input  logic                     code_valid,
  input  logic                     rec_start,
  input  logic                     rec_stop,
  input  logic                     play_start,
  output logic [3:0]               led,
  output logic                     busy,
  output logic                     pass,
  output logic                     fail,
  output logic [$clog2(DEPTH):0]   seq_len
);

  localparam int IW   = $clog2(DEPTH);
  localparam int LW   = IW + 1;
  localparam int MAXC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(MAXC) + 1;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [LW-1:0]   r_seq_len;
  logic [1:0]      r_mem [DEPTH];
  logic [3:0]      r_led;
  logic            r_busy, r_pass, r_fail;

  logic            w_cmd_stop, w_cmd_play;
  logic            w_wr, w_full_now, w_last;
  logic [LW-1:0]   w_len_after;
  logic [1:0]      w_first_code;
  logic            w_enter_on, w_enter_off;
  logic            w_tmr_load, w_tmr_done;
  logic [TW-1:0]   w_tmr_val;
  logic [IW-1:0]   w_next_idx;
  logic [3:0]      w_show_led;

  // rec_start outranks rec_stop, which outranks play_start.
  assign w_cmd_stop = !rec_start && rec_stop;
  assign w_cmd_play = !rec_start && !rec_stop && play_start;

  // A recorded code is stored this cycle; the length guard keeps writes inside memory.
  assign w_wr        = (r_state == ST_RECORD) && code_valid && !rec_start &&
                       (r_seq_len < LW'(DEPTH));
  assign w_full_now  = w_wr && (r_seq_len == LW'(DEPTH - 1));
  assign w_len_after = w_wr ? r_seq_len + LW'(1) : r_seq_len;
  assign w_last      = ({1'b0, r_idx} == r_seq_len - LW'(1));

  // A play issued in the same cycle as the first write has to show the incoming code.
  assign w_first_code = (r_seq_len == '0) ? code_in : r_mem[0];
  assign w_next_idx   = (r_state == ST_SHOW_OFF) ? r_idx + IW'(1) : '0;
  assign w_show_led   = code_to_led((r_state == ST_RECORD) ? w_first_code : r_mem[w_next_idx]);

  // Decide whether this edge starts a lit playback step.
  always_comb begin
    w_enter_on = 1'b0;
    case (r_state)
      ST_IDLE:          w_enter_on = w_cmd_play && (r_seq_len != '0);
      ST_RECORD:        w_enter_on = w_cmd_play && (w_len_after != '0);
      ST_SHOW_OFF:      w_enter_on = !rec_start && w_tmr_done && !w_last;
      ST_PASS, ST_FAIL: w_enter_on = w_cmd_play;
      default:          w_enter_on = 1'b0;
    endcase
  end

  assign w_enter_off = (r_state == ST_SHOW_ON) && !rec_start && w_tmr_done;
  assign w_tmr_load  = w_enter_on || w_enter_off;
  assign w_tmr_val   = w_enter_on ? TW'(SHOW_CYCLES) : TW'(GAP_CYCLES);

  step_timer #(.TW(TW)) u_step_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_val),
    .o_done  (w_tmr_done)
  );

  // Sequence memory: written only while recording, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 2'b00;
    end else if (w_wr) begin
      r_mem[r_seq_len[IW-1:0]] <= code_in;
    end
  end

  // Game FSM with registered LED and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_seq_len <= '0;
      r_led     <= '0;
      r_busy    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_led <= '0;
      if (w_wr) r_seq_len <= r_seq_len + LW'(1);

      if (rec_start) begin
        r_state                  <= ST_RECORD;
        {r_busy, r_pass, r_fail} <= state_flags(ST_RECORD);
        r_seq_len                <= '0;
        r_idx                    <= '0;
      end else if (w_enter_on) begin
        r_state                  <= ST_SHOW_ON;
        {r_busy, r_pass, r_fail} <= state_flags(ST_SHOW_ON);
        r_idx                    <= w_next_idx;
        r_led                    <= w_show_led;
      end else begin
        case (r_state)
          ST_IDLE: ;
          ST_RECORD: begin
            if (w_wr) r_led <= code_to_led(code_in);
            if (w_cmd_stop || w_cmd_play || w_full_now) begin
              r_state                  <= ST_IDLE;
              {r_busy, r_pass, r_fail} <= state_flags(ST_IDLE);
            end
          end
          ST_SHOW_ON: begin
            if (w_enter_off) begin
              r_state                  <= ST_SHOW_OFF;
              {r_busy, r_pass, r_fail} <= state_flags(ST_SHOW_OFF);
            end else begin
              r_led <= code_to_led(r_mem[r_idx]);
            end
          end
          ST_SHOW_OFF: begin
            // Reaching here with the timer done means the final step has gone dark.
            if (w_tmr_done) begin
              r_state                  <= ST_CHECK;
              {r_busy, r_pass, r_fail} <= state_flags(ST_CHECK);
              r_idx                    <= '0;
            end
          end
          ST_CHECK: begin
            if (code_valid) begin
              r_led <= code_to_led(code_in);
              if (code_in != r_mem[r_idx]) begin
                r_state                  <= ST_FAIL;
                {r_busy, r_pass, r_fail} <= state_flags(ST_FAIL);
              end else if (w_last) begin
                r_state                  <= ST_PASS;
                {r_busy, r_pass, r_fail} <= state_flags(ST_PASS);
              end else begin
                r_idx <= r_idx + IW'(1);
              end
            end
          end
          ST_PASS, ST_FAIL: begin
            if (w_cmd_stop) begin
              r_state                  <= ST_IDLE;
              {r_busy, r_pass, r_fail} <= state_flags(ST_IDLE);
            end
          end
          default: begin
            r_state                  <= ST_IDLE;
            {r_busy, r_pass, r_fail} <= state_flags(ST_IDLE);
          end
        endcase
      end
    end
  end

  assign led     = r_led;
  assign busy    = r_busy;
  assign pass    = r_pass;
  assign fail    = r_fail;
  assign seq_len = r_seq_len;

endmodule

// File: tb/tb_pattern_memory.sv
// Randomized bench for pattern_memory with a queue-based reference model.
module tb_pattern_memory;

  localparam int DEPTH = 4;
  localparam int SHOW  = 4;
  localparam int GAP   = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    code_in;
  logic          code_valid, rec_start, rec_stop, play_start;
  logic [3:0]    led;
  logic          busy, pass, fail;
  logic [LW-1:0] seq_len;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the stored sequence as a plain queue.
  logic [1:0] q_mem[$];

  pattern_memory #(
    .DEPTH       (DEPTH),
    .SHOW_CYCLES (SHOW),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_in    (code_in),
    .code_valid (code_valid),
    .rec_start  (rec_start),
    .rec_stop   (rec_stop),
    .play_start (play_start),
    .led        (led),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail),
    .seq_len    (seq_len)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] c);
    int sh;
    if (c == 2'b00) return 4'b1000;
    sh = int'(c) - 1;
    return 4'(1 << sh);
  endfunction

  // Advance one edge, then drop all pulse inputs a little after it.
  task automatic tick();
    @(posedge clk);
    #1;
    rec_start  = 1'b0;
    rec_stop   = 1'b0;
    play_start = 1'b0;
    code_valid = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic b, input logic p, input logic f);
    check_val({tag, "_busy"}, 32'(busy), 32'(b));
    check_val({tag, "_pass"}, 32'(pass), 32'(p));
    check_val({tag, "_fail"}, 32'(fail), 32'(f));
  endtask

  // Record a sequence (length <= DEPTH); ends in IDLE.
  task automatic do_record(input logic [1:0] codes[$]);
    rec_start = 1'b1;
    tick();
    q_mem.delete();
    check_flags("rec_start", 1'b1, 1'b0, 1'b0);
    check_val("rec_start_len", 32'(seq_len), 0);
    check_val("rec_start_led", 32'(led), 0);
    foreach (codes[i]) begin
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check_val("rec_gap_led", 32'(led), 0);
      end
      code_in    = codes[i];
      code_valid = 1'b1;
      tick();
      if (q_mem.size() < DEPTH) q_mem.push_back(codes[i]);
      check_val("rec_echo", 32'(led), 32'(onehot(codes[i])));
      check_val("rec_len", 32'(seq_len), 32'(q_mem.size()));
      check_val("rec_busy", 32'(busy), 32'(q_mem.size() < DEPTH));
    end
    if (q_mem.size() < DEPTH) begin
      rec_stop = 1'b1;
      tick();
      check_flags("rec_stop", 1'b0, 1'b0, 1'b0);
      check_val("rec_stop_len", 32'(seq_len), 32'(q_mem.size()));
    end
  endtask

  // Replay and compare every cycle against the timeline built from the model queue.
  task automatic do_play();
    logic [3:0] tr[$];
    foreach (q_mem[i]) begin
      repeat (SHOW) tr.push_back(onehot(q_mem[i]));
      repeat (GAP) tr.push_back(4'b0000);
    end
    play_start = 1'b1;
    tick();
    check_flags("play_start", 1'b1, 1'b0, 1'b0);
    check_val("play_led0", 32'(led), 32'(tr[0]));
    for (int i = 1; i < tr.size(); i++) begin
      tick();
      check_val("play_led", 32'(led), 32'(tr[i]));
    end
    tick();
    check_flags("check_entry", 1'b1, 1'b0, 1'b0);
    check_val("check_entry_led", 32'(led), 0);
  endtask

  // Enter the player's repeat; bad_pos >= length means a correct repeat.
  task automatic do_repeat(input int bad_pos);
    int n;
    logic [1:0] c;
    n = q_mem.size();
    for (int i = 0; i < n; i++) begin
      if (i == bad_pos)
        c = 2'((int'(q_mem[i]) + 1 + int'($urandom_range(0, 2))) % 4);
      else
        c = q_mem[i];
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check_val("rep_gap_led", 32'(led), 0);
      end
      code_in    = c;
      code_valid = 1'b1;
      tick();
      check_val("rep_echo", 32'(led), 32'(onehot(c)));
      if (i == bad_pos) begin
        check_flags("rep_fail", 1'b0, 1'b0, 1'b1);
        break;
      end else if (i == n - 1) begin
        check_flags("rep_pass", 1'b0, 1'b1, 1'b0);
      end else begin
        check_flags("rep_mid", 1'b1, 1'b0, 1'b0);
      end
    end
    tick();
    check_val("flag_hold_led", 32'(led), 0);
    check_flags("flag_hold", 1'b0, bad_pos >= n, bad_pos < n);
  endtask

  initial begin
    logic [1:0] codes[$];
    rst_n      = 1'b0;
    code_in    = 2'b00;
    code_valid = 1'b0;
    rec_start  = 1'b0;
    rec_stop   = 1'b0;
    play_start = 1'b0;
    tick();
    tick();
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    check_val("reset_led", 32'(led), 0);
    check_val("reset_len", 32'(seq_len), 0);
    rst_n = 1'b1;
    tick();

    // Asynchronous reset in the middle of recording.
    rec_start = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      code_in    = 2'($urandom_range(0, 3));
      code_valid = 1'b1;
      tick();
    end
    check_val("mid_rec_len", 32'(seq_len), 2);
    #2 rst_n = 1'b0;
    #1;
    check_flags("async_rst", 1'b0, 1'b0, 1'b0);
    check_val("async_rst_led", 32'(led), 0);
    check_val("async_rst_len", 32'(seq_len), 0);
    tick();
    rst_n = 1'b1;
    q_mem.delete();
    play_start = 1'b1;
    tick();
    check_val("empty_play_busy", 32'(busy), 0);
    check_val("empty_play_led", 32'(led), 0);

    // Directed: 01, 11, 00 then a correct repeat.
    codes = '{2'b01, 2'b11, 2'b00};
    do_record(codes);
    do_play();
    do_repeat(DEPTH + 1);

    // Replay from PASS, then wrong at the second code; replay from FAIL.
    do_play();
    do_repeat(1);
    do_play();
    do_repeat(DEPTH + 1);

    // Full memory: auto return to IDLE and a fifth code is dropped.
    codes = '{};
    for (int i = 0; i < DEPTH; i++) codes.push_back(2'($urandom_range(0, 3)));
    do_record(codes);
    code_in    = 2'($urandom_range(0, 3));
    code_valid = 1'b1;
    tick();
    check_val("full_extra_len", 32'(seq_len), DEPTH);
    check_val("full_extra_led", 32'(led), 0);
    check_val("full_extra_busy", 32'(busy), 0);
    do_play();
    do_repeat(DEPTH + 1);

    // rec_start and play_start together during playback: recording wins.
    play_start = 1'b1;
    tick();
    tick();
    rec_start  = 1'b1;
    play_start = 1'b1;
    tick();
    check_flags("prio_rec", 1'b1, 1'b0, 1'b0);
    check_val("prio_len", 32'(seq_len), 0);
    check_val("prio_led", 32'(led), 0);
    repeat (SHOW + GAP) tick();
    check_val("prio_stay_led", 32'(led), 0);
    check_val("prio_stay_busy", 32'(busy), 1);
    rec_stop = 1'b1;
    tick();
    q_mem.delete();
    check_flags("prio_stop", 1'b0, 1'b0, 1'b0);
    check_val("prio_stop_len", 32'(seq_len), 0);

    // Random sequences, replays and repeats.
    for (int it = 0; it < 15; it++) begin
      int n;
      n = int'($urandom_range(1, DEPTH));
      codes = '{};
      for (int i = 0; i < n; i++) codes.push_back(2'($urandom_range(0, 3)));
      do_record(codes);
      do_play();
      if ($urandom_range(0, 1) == 1) do_repeat(DEPTH + 1);
      else do_repeat(int'($urandom_range(0, n - 1)));
      if ($urandom_range(0, 1) == 1) begin
        rec_stop = 1'b1;
        tick();
        check_flags("rand_stop", 1'b0, 1'b0, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
